fetch_ifid_stage: RTL
=====================

Name: fetch_ifid_stage

Overview:
Fetch stage plus IF/ID pipeline register for the 16-bit 5-stage pipeline. It drives the instruction-memory address from the PC and registers the returned instruction into IF/ID. It decodes opcode/source fields for the load-use hazard detector, and consumes that detector's stall. It also takes the branch flush/redirect from Decode and sequences HLT draining into a terminal halted state.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HLT_OPCODE, 4'hF, opcode that halts fetch
NOP_INSTR, 16'h0000, instruction word written into IF/ID as a bubble

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  load-use stall from hazard detector; hold PC and IF/ID
flush  in  1  branch taken, resolved in Decode; redirect and squash IF/ID
branch_target  in  16  redirect PC, valid when flush=1
imem_addr  out  16  instruction-memory address (combinational = PC)
imem_data  in  16  instruction word, same-cycle combinational read
if_id_instr  out  16  registered instruction
if_id_pc_plus2  out  16  registered PC+2 of that instruction
if_id_valid  out  1  0 for a bubble
if_id_opcode  out  4  if_id_instr[15:12], feeds hazard detector
if_id_rs  out  4  if_id_instr[7:4]
if_id_rt  out  4  if_id_instr[3:0]
halted  out  1  1 once HLT has drained past Decode
stall_count  out  16  saturating count of cycles with stall=1 and flush=0 in state FETCH or HALT_WAIT

Behaviour:
- Reset values:
  - PC=RESET_PC
  - if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc_plus2=0
  - state=FETCH, halted=0, stall_count=0
- Priority: rst > flush > stall > normal advance.
- PC arithmetic: pc_plus2 = PC+2, 16-bit, wraps (16'hFFFE -> 16'h0000).
- State FETCH:
  - normal: PC<=pc_plus2; IF/ID<={imem_data, pc_plus2, valid=1}.
  - If imem_data[15:12]==HLT_OPCODE with no stall/flush:
    - IF/ID latches the HLT (valid=1).
    - PC holds at the HLT's address.
    - state<=HALT_WAIT.
  - stall: PC, IF/ID, and state all hold; imem_addr unchanged.
  - flush: PC<=branch_target; IF/ID<={NOP_INSTR, 0, valid=0}; stays FETCH, even if the current imem_data is HLT.
- State HALT_WAIT (HLT sitting in IF/ID):
  - stall: everything holds.
  - flush: the HLT was in a branch shadow and is cancelled. PC<=branch_target, IF/ID<=bubble, state<=FETCH.
  - otherwise: IF/ID<=bubble, PC holds, state<=HALTED.
- State HALTED:
  - terminal until rst; PC frozen, IF/ID bubble, halted=1.
  - stall and flush are ignored.
- Outputs if_id_opcode/rs/rt are pure slices of the IF/ID register (registered, zero combinational latency).
- Latency: an instruction at imem_addr in cycle N appears on if_id_* in cycle N+1.
- stall_count:
  - increments on qualifying cycles; saturates at 16'hFFFF and does not wrap.
  - rst clears it.
- Reset asserted mid-stall, mid-flush or in HALTED: the reset values above apply next edge; the in-flight instruction is discarded.

Decomposition:
- Shared package pipeline_pkg:
  - OPC_LW=4'h8, OPC_HLT=4'hF
  - NOP_INSTR
  - fetch_state_t enum {FETCH, HALT_WAIT, HALTED}
  - field slice index constants
- One natural sub-module: if_id_reg, the hold/squash-capable IF/ID register. Inputs: stall, flush, bubble, d-fields. It is reused shape-wise by later D/X and X/M registers.

Test Plan:
- Reset then run with imem returning 16'h1234 for every address:
  - cycle 1: imem_addr=0x0000;
  - then 0x0002, 0x0004;
  - if_id_instr=16'h1234 and if_id_pc_plus2=0x0002 one cycle after the first fetch.
- Assert stall for 2 cycles at PC=0x0006:
  - imem_addr stays 0x0006, IF/ID unchanged;
  - stall_count=2; advance resumes to 0x0008.
- Assert flush with branch_target=0x0040, stall=1 in the same cycle:
  - next cycle PC=0x0040, if_id_valid=0, if_id_instr=NOP_INSTR;
  - stall_count not incremented.
- Fetch 16'hF000 at 0x0010:
  - IF/ID holds HLT, PC stays 0x0010;
  - next cycle IF/ID becomes a bubble and halted=1;
  - halted stays 1 across later flush pulses until rst.
- HLT fetched, then flush (target 0x0100) in the HALT_WAIT cycle:
  - halted stays 0, PC=0x0100, fetch resumes.
- Preload PC to 0xFFFE via flush:
  - next normal advance gives imem_addr=0x0000;
  - if_id_pc_plus2=0x0000.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline.
// Contents: opcode constants, bubble instruction word, fetch state
// encoding and the bit positions of the instruction fields.
package pipeline_pkg;

  localparam logic [3:0]  OPC_LW    = 4'h8;
  localparam logic [3:0]  OPC_HLT   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Instruction field positions: [15:12] opcode, [7:4] rs, [3:0] rt
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_stage_if_id_reg.sv
// if_id_reg: hold/squash-capable pipeline register for IF/ID.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hold current contents
//   flush             load a bubble (wins over stall)
//   bubble            load a bubble when not stalled
//   d_instr/d_pc_plus2/d_valid   next-stage fields
//   q_instr/q_pc_plus2/q_valid   registered fields
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [15:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        bubble,
  input  logic [15:0] d_instr,
  input  logic [15:0] d_pc_plus2,
  input  logic        d_valid,
  output logic [15:0] q_instr,
  output logic [15:0] q_pc_plus2,
  output logic        q_valid
);

  logic [15:0] instr_reg;
  logic [15:0] pc_plus2_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_reg    <= BUBBLE_INSTR;
      pc_plus2_reg <= 16'h0000;
      valid_reg    <= 1'b0;
    end else if (stall) begin
      instr_reg    <= instr_reg;
      pc_plus2_reg <= pc_plus2_reg;
      valid_reg    <= valid_reg;
    end else if (bubble) begin
      instr_reg    <= BUBBLE_INSTR;
      pc_plus2_reg <= 16'h0000;
      valid_reg    <= 1'b0;
    end else begin
      instr_reg    <= d_instr;
      pc_plus2_reg <= d_pc_plus2;
      valid_reg    <= d_valid;
    end
  end

  assign q_instr    = instr_reg;
  assign q_pc_plus2 = pc_plus2_reg;
  assign q_valid    = valid_reg;

endmodule

// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC, instruction fetch and IF/ID register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           load-use stall: hold PC and IF/ID
//   flush           taken branch from Decode: redirect, squash IF/ID
//   branch_target   redirect PC when flush=1
//   imem_addr       instruction memory address (= PC)
//   imem_data       instruction word for imem_addr, same cycle
//   if_id_*         registered instruction, PC+2, valid and field slices
//   halted          HLT has drained past Decode
//   stall_count     saturating count of qualifying stall cycles
module fetch_ifid_stage
  import pipeline_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = OPC_HLT,
  parameter logic [15:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic [3:0]  if_id_opcode,
  output logic [3:0]  if_id_rs,
  output logic [3:0]  if_id_rt,
  output logic        halted,
  output logic [15:0] stall_count
);

  fetch_state_t state_reg, state_next;
  logic [15:0]  pc_reg, pc_next;
  logic [15:0]  stall_count_reg, stall_count_next;
  logic [15:0]  pc_plus2;
  logic         fetch_is_hlt;
  logic         reg_stall, reg_flush, reg_bubble;

  assign pc_plus2     = pc_reg + 16'd2;
  assign fetch_is_hlt = (imem_data[OPC_MSB:OPC_LSB] == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      stall_count_reg <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      stall_count_reg <= stall_count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    reg_stall  = 1'b0;
    reg_flush  = 1'b0;
    reg_bubble = 1'b0;
    unique case (state_reg)
      FETCH: begin
        if (flush) begin
          // A HLT in the branch shadow is simply not taken.
          pc_next   = branch_target;
          reg_flush = 1'b1;
        end else if (stall) begin
          reg_stall = 1'b1;
        end else if (fetch_is_hlt) begin
          // HLT enters IF/ID; PC parks on it while it drains.
          state_next = HALT_WAIT;
        end else begin
          pc_next = pc_plus2;
        end
      end
      HALT_WAIT: begin
        if (flush) begin
          pc_next    = branch_target;
          reg_flush  = 1'b1;
          state_next = FETCH;
        end else if (stall) begin
          reg_stall = 1'b1;
        end else begin
          reg_bubble = 1'b1;
          state_next = HALTED;
        end
      end
      HALTED: begin
        reg_bubble = 1'b1;
      end
      default: begin
        reg_bubble = 1'b1;
        state_next = FETCH;
      end
    endcase
  end

  // Counts stall cycles that actually hold the pipeline (flush overrides).
  always_comb begin
    stall_count_next = stall_count_reg;
    if (stall && !flush && (state_reg != HALTED) && (stall_count_reg != 16'hFFFF))
      stall_count_next = stall_count_reg + 16'd1;
  end

  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (reg_stall),
    .flush      (reg_flush),
    .bubble     (reg_bubble),
    .d_instr    (imem_data),
    .d_pc_plus2 (pc_plus2),
    .d_valid    (1'b1),
    .q_instr    (if_id_instr),
    .q_pc_plus2 (if_id_pc_plus2),
    .q_valid    (if_id_valid)
  );

  assign imem_addr    = pc_reg;
  assign if_id_opcode = if_id_instr[OPC_MSB:OPC_LSB];
  assign if_id_rs     = if_id_instr[RS_MSB:RS_LSB];
  assign if_id_rt     = if_id_instr[RT_MSB:RT_LSB];
  assign halted       = (state_reg == HALTED);
  assign stall_count  = stall_count_reg;

endmodule
